// File: rtl/fp_pack.sv
// Normalize / round-to-nearest-even / pack stage of the binary64 adder.
// One normalization shift per cycle; valid/ready on both sides, one operation in flight.
module fp_pack #(
    parameter int EW = 13,
    parameter int FW = 57
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 s,
    input  logic signed [EW-1:0] e,
    input  logic        [FW-1:0] f,
    input  logic                 INFs,
    input  logic                 NANs,
    input  logic                 INV,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic        [63:0]   z,
    output logic                 ovf,
    output logic                 inx
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_NORM  = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Rounded mantissa width: hidden bit plus 52 fraction bits.
    localparam int MW = FW - 4;

    localparam logic signed [EW-1:0] E_ONE  = EW'(1);
    localparam logic signed [EW-1:0] E_MAX  = EW'(2047);
    localparam logic signed [EW-1:0] E_COLL = EW'(-57);
    localparam logic        [63:0]   QNAN   = 64'h7FF8_0000_0000_0000;

    logic [1:0]           r_state;
    logic                 r_s;
    logic signed [EW-1:0] r_e;
    logic        [FW-1:0] r_f;
    logic                 r_stk;
    logic [63:0]          r_z;
    logic                 r_ovf;
    logic                 r_inx;

    logic        [FW-1:0] w_nf;
    logic signed [EW-1:0] w_ne;
    logic                 w_shout;
    logic                 w_g;
    logic                 w_rs;
    logic                 w_inc;
    logic        [MW:0]   w_rsum;
    logic                 w_rcarry;
    logic        [MW-1:0] w_rmant;
    logic signed [EW-1:0] w_re;
    logic [63:0]          w_z;
    logic                 w_ovf;
    logic                 w_inx;

    // True while the (F, E) pair still needs a NORM action; lets the FSM skip NORM when idle.
    function automatic logic needs_norm(input logic [FW-1:0] fv, input logic signed [EW-1:0] ev);
        return fv[FW-1] || (ev < E_ONE) || (!fv[FW-2] && (ev > E_ONE));
    endfunction

    function automatic logic rne_up(input logic lsb, input logic g, input logic rs);
        return g & (rs | lsb);
    endfunction

    assign in_ready  = (r_state == ST_IDLE) & rst_n;
    assign out_valid = (r_state == ST_DONE);
    assign z         = r_z;
    assign ovf       = r_ovf;
    assign inx       = r_inx;

    always_comb begin
        w_nf    = r_f;
        w_ne    = r_e;
        w_shout = 1'b0;
        if (r_f[FW-1]) begin
            w_nf    = {1'b0, r_f[FW-1:2], r_f[1] | r_f[0]};
            w_ne    = r_e + E_ONE;
            w_shout = r_f[0];
        end else if (r_e < E_ONE) begin
            // Far below the denormal range every bit ends up in sticky, so collapse in one step.
            if (r_e < E_COLL) begin
                w_nf    = {{(FW-1){1'b0}}, |r_f};
                w_ne    = E_ONE;
                w_shout = |r_f;
            end else begin
                w_nf    = {1'b0, r_f[FW-1:2], r_f[1] | r_f[0]};
                w_ne    = r_e + E_ONE;
                w_shout = r_f[0];
            end
        end else if (!r_f[FW-2] && (r_e > E_ONE)) begin
            w_nf = {r_f[FW-2:0], 1'b0};
            w_ne = r_e - E_ONE;
        end
    end

    always_comb begin
        w_g      = r_f[2];
        w_rs     = |r_f[1:0];
        w_inc    = rne_up(r_f[3], w_g, w_rs);
        w_rsum   = {1'b0, r_f[FW-2:3]} + {{MW{1'b0}}, w_inc};
        w_rcarry = w_rsum[MW];
        w_rmant  = w_rcarry ? w_rsum[MW:1] : w_rsum[MW-1:0];
        w_re     = w_rcarry ? (r_e + E_ONE) : r_e;
        w_inx    = w_g | w_rs | r_stk;
        w_ovf    = 1'b0;
        if (w_re >= E_MAX) begin
            w_z   = {r_s, 11'h7FF, 52'd0};
            w_ovf = 1'b1;
            w_inx = 1'b1;
        end else begin
            // A denormal that rounds into the hidden bit picks up exponent field 1 from E=1.
            w_z = {r_s, (w_rmant[MW-1] ? w_re[10:0] : 11'd0), w_rmant[MW-2:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_z     <= '0;
            r_ovf   <= 1'b0;
            r_inx   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_s   <= s;
                        r_e   <= e;
                        r_f   <= f;
                        r_stk <= 1'b0;
                        if (INV || NANs) begin
                            r_z     <= QNAN;
                            r_ovf   <= 1'b0;
                            r_inx   <= 1'b0;
                            r_state <= ST_DONE;
                        end else if (INFs) begin
                            r_z     <= {s, 11'h7FF, 52'd0};
                            r_ovf   <= 1'b0;
                            r_inx   <= 1'b0;
                            r_state <= ST_DONE;
                        end else if (f == '0) begin
                            r_z     <= {s, 63'd0};
                            r_ovf   <= 1'b0;
                            r_inx   <= 1'b0;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= needs_norm(f, e) ? ST_NORM : ST_ROUND;
                        end
                    end
                end
                ST_NORM: begin
                    r_f     <= w_nf;
                    r_e     <= w_ne;
                    r_stk   <= r_stk | w_shout;
                    r_state <= needs_norm(w_nf, w_ne) ? ST_NORM : ST_ROUND;
                end
                ST_ROUND: begin
                    r_z     <= w_z;
                    r_ovf   <= w_ovf;
                    r_inx   <= w_inx;
                    r_state <= ST_DONE;
                end
                default: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_pack.sv
// Directed bench for fp_pack: vector table for values/latency, plus hold and mid-op reset sequences.
module tb_fp_pack;

    localparam int EW = 13;
    localparam int FW = 57;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic                 s = 1'b0;
    logic signed [EW-1:0] e = '0;
    logic        [FW-1:0] f = '0;
    logic                 INFs = 1'b0;
    logic                 NANs = 1'b0;
    logic                 INV = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic        [63:0]   z;
    logic                 ovf;
    logic                 inx;

    int errors = 0;
    int checks = 0;

    fp_pack #(.EW(EW), .FW(FW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .s(s), .e(e), .f(f), .INFs(INFs), .NANs(NANs), .INV(INV),
        .out_valid(out_valid), .out_ready(out_ready), .z(z), .ovf(ovf), .inx(inx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                 s;
        logic signed [EW-1:0] e;
        logic        [FW-1:0] f;
        logic                 infs;
        logic                 nans;
        logic                 inv;
        logic        [63:0]   z;
        logic                 ovf;
        logic                 inx;
        int                   lat;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic vs, input logic signed [EW-1:0] ve, input logic [FW-1:0] vf,
                                input logic vinf, input logic vnan, input logic vinv,
                                input logic [63:0] vz, input logic vovf, input logic vinx, input int vlat);
        vec_t v;
        v.s = vs; v.e = ve; v.f = vf; v.infs = vinf; v.nans = vnan; v.inv = vinv;
        v.z = vz; v.ovf = vovf; v.inx = vinx; v.lat = vlat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Latency counts the cycle right after the accept edge as 1.
    task automatic run_op(input vec_t v, input int idx);
        int lat;
        s = v.s; e = v.e; f = v.f; INFs = v.infs; NANs = v.nans; INV = v.inv;
        in_valid = 1'b1;
        chk($sformatf("v%0d_in_ready_pre", idx), 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        s = ~v.s; e = '0; f = '1; INFs = 1'b1; NANs = 1'b1; INV = 1'b1;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        INFs = 1'b0; NANs = 1'b0; INV = 1'b0;
        chk($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.lat));
        chk($sformatf("v%0d_z", idx), z, v.z);
        chk($sformatf("v%0d_ovf", idx), 64'(ovf), 64'(v.ovf));
        chk($sformatf("v%0d_inx", idx), 64'(inx), 64'(v.inx));
        chk($sformatf("v%0d_in_ready_busy", idx), 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk($sformatf("v%0d_out_valid_after", idx), 64'(out_valid), 64'd0);
        chk($sformatf("v%0d_in_ready_after", idx), 64'(in_ready), 64'd1);
    endtask

    initial begin
        vecs[0]  = mk(1'b0, 13'sd1023, 57'd1 << 55, 0, 0, 0, 64'h3FF0000000000000, 0, 0, 2);
        vecs[1]  = mk(1'b0, 13'sd1023, 57'd1 << 56, 0, 0, 0, 64'h4000000000000000, 0, 0, 3);
        vecs[2]  = mk(1'b0, 13'sd1028, 57'd1 << 50, 0, 0, 0, 64'h3FF0000000000000, 0, 0, 7);
        vecs[3]  = mk(1'b0, 13'sd1023, (57'd1 << 55) | 57'd4, 0, 0, 0, 64'h3FF0000000000000, 0, 1, 2);
        vecs[4]  = mk(1'b0, 13'sd1023, (57'd1 << 55) | 57'd12, 0, 0, 0, 64'h3FF0000000000002, 0, 1, 2);
        vecs[5]  = mk(1'b0, 13'sd1023, 57'h0FFFFFFFFFFFFFC, 0, 0, 0, 64'h4000000000000000, 0, 1, 2);
        vecs[6]  = mk(1'b0, 13'sd1023, 57'd1 << 55, 0, 0, 1, 64'h7FF8000000000000, 0, 0, 1);
        vecs[7]  = mk(1'b1, 13'sd1023, 57'd1 << 55, 1, 0, 0, 64'hFFF0000000000000, 0, 0, 1);
        vecs[8]  = mk(1'b1, 13'sd1023, 57'd1 << 55, 1, 1, 0, 64'h7FF8000000000000, 0, 0, 1);
        vecs[9]  = mk(1'b0, 13'sd2047, 57'd1 << 55, 0, 0, 0, 64'h7FF0000000000000, 1, 1, 2);
        vecs[10] = mk(1'b0, 13'sd0, 57'd1 << 55, 0, 0, 0, 64'h0008000000000000, 0, 0, 3);
        vecs[11] = mk(1'b0, -13'sd100, 57'd1 << 55, 0, 0, 0, 64'h0000000000000000, 0, 1, 3);
        vecs[12] = mk(1'b1, 13'sd1023, 57'd0, 0, 0, 0, 64'h8000000000000000, 0, 0, 1);
        vecs[13] = mk(1'b1, 13'sd1024, 57'd3 << 54, 0, 0, 0, 64'hC008000000000000, 0, 0, 2);
        vecs[14] = mk(1'b0, 13'sd1, 57'h07FFFFFFFFFFFFC, 0, 0, 0, 64'h0010000000000000, 0, 1, 2);
        vecs[15] = mk(1'b0, 13'sd2046, 57'h0FFFFFFFFFFFFFC, 0, 0, 0, 64'h7FF0000000000000, 1, 1, 2);
        vecs[16] = mk(1'b0, 13'sd3, 57'd1 << 52, 0, 0, 0, 64'h0008000000000000, 0, 0, 4);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_z", z, 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_inx", 64'(inx), 64'd0);
        chk("rst_in_ready_low", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready_release", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++) begin
            run_op(vecs[i], i);
        end

        // Back-pressure: result must hold while out_ready stays low.
        begin
            int wait_cyc;
            s = 1'b0; e = 13'sd1023; f = 57'd1 << 55;
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            wait_cyc = 0;
            while (!out_valid && wait_cyc < 200) begin
                @(posedge clk); #1;
                wait_cyc++;
            end
            chk("hold_reached_valid", 64'(out_valid), 64'd1);
            for (int k = 0; k < 5; k++) begin
                @(posedge clk); #1;
                chk($sformatf("hold%0d_out_valid", k), 64'(out_valid), 64'd1);
                chk($sformatf("hold%0d_z", k), z, 64'h3FF0000000000000);
                chk($sformatf("hold%0d_in_ready", k), 64'(in_ready), 64'd0);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk("hold_release_in_ready", 64'(in_ready), 64'd1);
        end

        // Reset in the middle of a multi-cycle normalization.
        begin
            logic seen;
            s = 1'b0; e = 13'sd1028; f = 57'd1 << 50;
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b0;
            #1;
            chk("midrst_in_ready_low", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
            rst_n = 1'b1;
            #1;
            chk("midrst_in_ready_after", 64'(in_ready), 64'd1);
            chk("midrst_out_valid_after", 64'(out_valid), 64'd0);
            seen = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(posedge clk); #1;
                seen = seen | out_valid;
            end
            chk("midrst_no_output", 64'(seen), 64'd0);
            run_op(vecs[2], 102);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_pack.md
# fp_pack

Sequential normalize/round/pack stage for the double-precision adder. It sits downstream of the special-value classifier and the significand adder. It takes the unpacked sum (sign, wide exponent, significand with guard/round/sticky) plus the classifier's INFs/NANs/INV flags, and emits a packed IEEE-754 binary64 word. Input and output use valid/ready handshakes, and normalization shifts run one bit per cycle.

## Interface
Parameters:
- EW, 13, signed width of incoming biased exponent
- FW, 57, incoming significand width: [56] carry, [55] hidden, [54:3] fraction, [2:0] guard/round/sticky

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operand present
- in_ready  out  1  block can accept; equals (state==IDLE) & rst_n
- s  in  1  result sign
- e  in  EW  biased exponent, two's complement, may be <=0 or >=2047
- f  in  FW  significand; value = f * 2^(e-1023-55)
- INFs  in  1  result is infinity (from classifier)
- NANs  in  1  NaN operand present
- INV  in  1  invalid operation (inf - inf)
- out_valid  out  1  z valid, held until out_ready
- out_ready  in  1  consumer accepts
- z  out  64  packed binary64 result
- ovf  out  1  overflow to infinity occurred
- inx  out  1  result inexact (any G/R/S or shifted-out bit nonzero)

## Operation
- States: IDLE, NORM, ROUND, DONE. Capture in IDLE on in_valid & in_ready into internal regs S, E (EW bits), F (FW bits), and the sticky accumulator.
- IDLE with accept:
  - INV | NANs → DONE, z = 0x7FF8000000000000, sign 0.
  - else INFs → DONE, z = {s, 0x7FF, 52'b0}.
  - else f == 0 → DONE, z = {s, 63'b0}.
  - else → NORM.
- NORM: exactly one action per cycle, in priority order:
  - F[56]=1: F>>=1, shifted bit OR'd into F[0] (sticky), E+=1.
  - E<1: F>>=1 with sticky, E+=1 (denormalize).
  - F[55]=0 and E>1: F<<=1, E-=1.
  - else → ROUND.
  - E < -57 on entry to the E<1 case: F collapses to {56'b0, |F}, E=1, in one cycle.
- ROUND, round-to-nearest-even:
  - lsb=F[3], g=F[2], rs=|F[1:0]; increment F[55:3] if g & (rs | lsb).
  - Carry into bit 56 → F>>=1, E+=1 in the same cycle.
  - Denormal whose increment sets F[55] → E stays 1 and exponent field becomes 1.
  - inx = g | rs | sticky history.
  - E>=2047 → z = {S, 0x7FF, 52'b0}, ovf=1, inx=1.
  - else exponent field = F[55] ? E[10:0] : 0, fraction = F[54:3].
  - → DONE.
- DONE: out_valid=1. z, ovf and inx are stable until out_ready. On out_valid & out_ready → IDLE.
- ovf/inx are 0 for all special-bypass results.

## Timing
- Reset (rst_n=0 at a clk edge):
  - State → IDLE; z=0, out_valid=0, ovf=0, inx=0.
  - in_ready reads 0 while rst_n=0.
  - Any operation in flight is discarded without producing output.
- Accept at cycle t:
  - Special/zero: out_valid at t+1.
  - Otherwise: out_valid at t+2+n, where n = NORM shift cycles.
  - Worst case n = 55 left shifts, or 58 for deep denormals.
- No overlap: in_ready is 0 from t+1 until the cycle after the output handshake. Accept and complete never coincide.
- out_ready is ignored unless out_valid=1. With out_ready held low, out_valid and z stay constant indefinitely.
- INFs/NANs/INV/s/e/f are sampled only on the accept edge.

## Test plan
- s=0, e=1023, f=1<<55 → z=0x3FF0000000000000, out_valid at t+2, inx=0, ovf=0.
- Carry: e=1023, f=1<<56 → z=0x4000000000000000 at t+3. Leading zeros: e=1028, f=1<<50 → z=0x3FF0000000000000 at t+7.
- RNE tie:
  - f=(1<<55)|4, e=1023 → z=0x3FF0000000000000, inx=1.
  - f=(1<<55)|12 → z=0x3FF0000000000002, inx=1.
  - f=0xFFFFFFFFFFFFFC<<0 with all fraction and G bits set → exponent increments to 0x400, fraction 0.
- Specials: INV=1 → z=0x7FF8000000000000 at t+1. INFs=1, s=1 → z=0xFFF0000000000000. NANs=1 with INFs=1 → NaN wins.
- Overflow/underflow:
  - e=2047, f=1<<55 → z=0x7FF0000000000000, ovf=1.
  - e=0, f=1<<55 → z=0x0008000000000000 (denormal, 1 right shift), inx=0.
  - e=-100, f=1<<55 → z=0, inx=1.
- Handshake/reset:
  - Hold out_ready=0 for 5 cycles: z and out_valid stable, in_ready=0.
  - Pulse rst_n=0 during NORM of the f=1<<50 case: out_valid never rises for that op, in_ready=1 the cycle after rst_n returns high, and the next op completes normally.
